// File: rtl/multi_mode_game_ctrl_if.sv
// Bundle between the game referee and its host / multi-mode counter.
// The master side is the referee; the slave side is the host and the counter.
interface multi_mode_game_ctrl_if;
    logic       start;
    logic [1:0] cfg_mode;
    logic [4:0] cfg_init_val;
    logic       rotate;
    logic       winner;
    logic       loser;
    logic       gameover;
    logic [4:0] count;
    logic [1:0] mode;
    logic       init;
    logic [4:0] init_val;
    logic       ctr_clr;
    logic       busy;
    logic       done;
    logic [3:0] round;
    logic [7:0] win_total;
    logic [7:0] lose_total;
    logic [4:0] last_count;
    logic       timeout;

    modport master (
        input  start, cfg_mode, cfg_init_val, rotate, winner, loser, gameover, count,
        output mode, init, init_val, ctr_clr, busy, done, round,
               win_total, lose_total, last_count, timeout
    );

    modport slave (
        output start, cfg_mode, cfg_init_val, rotate, winner, loser, gameover, count,
        input  mode, init, init_val, ctr_clr, busy, done, round,
               win_total, lose_total, last_count, timeout
    );
endinterface

// File: rtl/multi_mode_game_ctrl.sv
// Session referee for a multi-mode counter: clear, load, run and tally rounds.
// Outputs are registered from the next state; start is only seen in IDLE.
module multi_mode_game_ctrl #(
    parameter int INIT_CYCLES = 2,
    parameter int ROUNDS      = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic                        clk,
    input  logic                        rst,
    multi_mode_game_ctrl_if.master      bus
);
    typedef enum logic [2:0] {IDLE, CLR, LOAD, RUN, NEXT} state_t;

    localparam logic [3:0]  LAST_ROUND = 4'(ROUNDS - 1);
    localparam logic [3:0]  INIT_LAST  = 4'(INIT_CYCLES - 1);
    localparam logic [11:0] WD_LAST    = 12'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [4:0]  init_val_q, init_val_d;
    logic        init_q, init_d;
    logic        ctr_clr_q, ctr_clr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  round_q, round_d;
    logic [7:0]  win_total_q, win_total_d;
    logic [7:0]  lose_total_q, lose_total_d;
    logic [4:0]  last_count_q, last_count_d;
    logic        timeout_q, timeout_d;
    logic        win_prev_q, win_prev_d;
    logic        lose_prev_q, lose_prev_d;
    logic [3:0]  init_cnt_q, init_cnt_d;
    logic [11:0] wd_q, wd_d;
    logic        win_edge, lose_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= '0;
            init_val_q   <= '0;
            init_q       <= 1'b0;
            ctr_clr_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            round_q      <= '0;
            win_total_q  <= '0;
            lose_total_q <= '0;
            last_count_q <= '0;
            timeout_q    <= 1'b0;
            win_prev_q   <= 1'b0;
            lose_prev_q  <= 1'b0;
            init_cnt_q   <= '0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            init_val_q   <= init_val_d;
            init_q       <= init_d;
            ctr_clr_q    <= ctr_clr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            round_q      <= round_d;
            win_total_q  <= win_total_d;
            lose_total_q <= lose_total_d;
            last_count_q <= last_count_d;
            timeout_q    <= timeout_d;
            win_prev_q   <= win_prev_d;
            lose_prev_q  <= lose_prev_d;
            init_cnt_q   <= init_cnt_d;
            wd_q         <= wd_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        init_val_d   = init_val_q;
        done_d       = 1'b0;
        round_d      = round_q;
        win_total_d  = win_total_q;
        lose_total_d = lose_total_q;
        last_count_d = last_count_q;
        timeout_d    = timeout_q;
        win_prev_d   = win_prev_q;
        lose_prev_d  = lose_prev_q;
        init_cnt_d   = init_cnt_q;
        wd_d         = wd_q;
        win_edge     = bus.winner & ~win_prev_q;
        lose_edge    = bus.loser & ~lose_prev_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d       = bus.cfg_mode;
                    init_val_d   = bus.cfg_init_val;
                    round_d      = '0;
                    win_total_d  = '0;
                    lose_total_d = '0;
                    last_count_d = '0;
                    timeout_d    = 1'b0;
                    state_d      = CLR;
                end
            end
            CLR: begin
                // Prev levels cleared so a level already high at RUN entry counts.
                win_prev_d  = 1'b0;
                lose_prev_d = 1'b0;
                init_cnt_d  = '0;
                state_d     = LOAD;
            end
            LOAD: begin
                if (init_cnt_q == INIT_LAST) begin
                    wd_d    = '0;
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 4'd1;
                end
            end
            RUN: begin
                win_prev_d  = bus.winner;
                lose_prev_d = bus.loser;
                if (win_edge && (win_total_q != 8'hFF)) win_total_d = win_total_q + 8'd1;
                if (lose_edge && (lose_total_q != 8'hFF)) lose_total_d = lose_total_q + 8'd1;
                if (bus.gameover) begin
                    last_count_d = bus.count;
                    wd_d         = '0;
                    state_d      = NEXT;
                end else if (win_edge || lose_edge) begin
                    wd_d = '0;
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + 12'd1;
                end
            end
            NEXT: begin
                if (round_q == LAST_ROUND) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    round_d = round_q + 4'd1;
                    if (bus.rotate) mode_d = mode_q + 2'd1;
                    state_d = CLR;
                end
            end
            default: state_d = IDLE;
        endcase

        ctr_clr_d = (state_d == CLR);
        init_d    = (state_d == LOAD);
        busy_d    = (state_d != IDLE);
    end

    assign bus.mode       = mode_q;
    assign bus.init       = init_q;
    assign bus.init_val   = init_val_q;
    assign bus.ctr_clr    = ctr_clr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.round      = round_q;
    assign bus.win_total  = win_total_q;
    assign bus.lose_total = lose_total_q;
    assign bus.last_count = last_count_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_multi_mode_game_ctrl.sv
// Directed bench: single-round/short-watchdog instance and a four-round instance.
module tb_multi_mode_game_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   clr_cnt_b = 0;
    logic [1:0] exp_mode [4];

    multi_mode_game_ctrl_if ifa ();
    multi_mode_game_ctrl_if ifb ();

    multi_mode_game_ctrl #(.INIT_CYCLES(2), .ROUNDS(1), .TIMEOUT(8)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    multi_mode_game_ctrl #(.INIT_CYCLES(2), .ROUNDS(4), .TIMEOUT(1023)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ifb.ctr_clr === 1'b1) clr_cnt_b++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_mode[0] = 2'd2; exp_mode[1] = 2'd3; exp_mode[2] = 2'd0; exp_mode[3] = 2'd1;
        {ifa.start, ifa.cfg_mode, ifa.cfg_init_val, ifa.rotate} = '0;
        {ifa.winner, ifa.loser, ifa.gameover, ifa.count} = '0;
        {ifb.start, ifb.cfg_mode, ifb.cfg_init_val, ifb.rotate} = '0;
        {ifb.winner, ifb.loser, ifb.gameover, ifb.count} = '0;

        // Reset values
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", ifa.busy, 0);
        chk("rst_done", ifa.done, 0);
        chk("rst_outs", {ifa.mode, ifa.init, ifa.init_val, ifa.ctr_clr, ifa.round,
                         ifa.win_total, ifa.lose_total, ifa.last_count, ifa.timeout}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Basic session with tally and gameover capture
        ifa.start = 1'b1; ifa.cfg_mode = 2'd3; ifa.cfg_init_val = 5'd31;
        tick();
        ifa.start = 1'b0;
        chk("basic_clr", ifa.ctr_clr, 1);
        chk("basic_busy", ifa.busy, 1);
        tick();
        chk("basic_clr_1cyc", ifa.ctr_clr, 0);
        chk("basic_init0", ifa.init, 1);
        chk("basic_init_val", ifa.init_val, 31);
        chk("basic_mode", ifa.mode, 3);
        tick();
        chk("basic_init1", ifa.init, 1);
        chk("basic_init_val1", ifa.init_val, 31);
        tick();
        chk("basic_init_end", ifa.init, 0);
        ifa.winner = 1'b1; ifa.loser = 1'b0; tick();
        ifa.winner = 1'b0; ifa.loser = 1'b1; tick();
        ifa.winner = 1'b1; ifa.loser = 1'b0; tick();
        ifa.winner = 1'b0; ifa.loser = 1'b0; tick();
        ifa.winner = 1'b1; ifa.loser = 1'b1; tick();
        ifa.winner = 1'b0; ifa.loser = 1'b0; tick();
        chk("tally_win", ifa.win_total, 3);
        chk("tally_lose", ifa.lose_total, 2);
        chk("tally_busy", ifa.busy, 1);
        ifa.winner = 1'b1; ifa.gameover = 1'b1; ifa.count = 5'd15;
        tick();
        ifa.winner = 1'b0; ifa.gameover = 1'b0; ifa.count = 5'd0;
        chk("go_last_count", ifa.last_count, 15);
        chk("go_win_counted", ifa.win_total, 4);
        tick();
        chk("basic_done", ifa.done, 1);
        chk("basic_idle_busy", ifa.busy, 0);
        tick();
        chk("basic_done_once", ifa.done, 0);
        chk("hold_win", ifa.win_total, 4);
        chk("hold_last", ifa.last_count, 15);

        // Watchdog: no events for 8 RUN cycles
        ifa.start = 1'b1; ifa.cfg_mode = 2'd1; ifa.cfg_init_val = 5'd4;
        tick();
        ifa.start = 1'b0;
        chk("wd_cleared_totals", {ifa.win_total, ifa.lose_total, ifa.last_count}, 0);
        tick(); tick(); tick();
        chk("wd_in_run", ifa.init, 0);
        for (int k = 0; k < 7; k++) tick();
        chk("wd_not_yet", ifa.timeout, 0);
        chk("wd_still_busy", ifa.busy, 1);
        tick();
        chk("wd_timeout", ifa.timeout, 1);
        chk("wd_done", ifa.done, 1);
        chk("wd_busy", ifa.busy, 0);
        chk("wd_round", ifa.round, 0);
        tick();
        chk("wd_done_once", ifa.done, 0);
        chk("wd_sticky", ifa.timeout, 1);

        // Reset during LOAD
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick();
        chk("rl_in_load", ifa.init, 1);
        #1 rst = 1'b1;
        #1;
        chk("rl_init", ifa.init, 0);
        chk("rl_busy", ifa.busy, 0);
        chk("rl_done", ifa.done, 0);
        tick();
        chk("rl_done_held", ifa.done, 0);
        rst = 1'b0; ifa.start = 1'b1;
        tick();
        chk("rl_start_accepted", ifa.ctr_clr, 1);
        tick(); tick(); tick();
        chk("rl_run", ifa.init, 0);
        tick(); tick(); tick();
        chk("start_ignored_clr", ifa.ctr_clr, 0);
        chk("start_ignored_busy", ifa.busy, 1);
        ifa.start = 1'b0; ifa.gameover = 1'b1; ifa.count = 5'd7;
        tick();
        ifa.gameover = 1'b0;
        chk("rl_last_count", ifa.last_count, 7);
        tick();
        chk("rl_done_end", ifa.done, 1);

        // Rotation over four rounds
        ifb.start = 1'b1; ifb.cfg_mode = 2'd2; ifb.rotate = 1'b1;
        tick();
        ifb.start = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 10 && ifb.init !== 1'b1; k++) tick();
            chk("rot_init_seen", ifb.init, 1);
            chk("rot_mode", ifb.mode, exp_mode[r]);
            chk("rot_round", ifb.round, r);
            for (int k = 0; k < 10 && ifb.init === 1'b1; k++) tick();
            ifb.gameover = 1'b1; ifb.count = 5'(r);
            tick();
            ifb.gameover = 1'b0;
            tick();
            if (r == 3) begin
                chk("rot_done", ifb.done, 1);
                chk("rot_busy", ifb.busy, 0);
                chk("rot_round_end", ifb.round, 3);
            end
        end
        tick();
        chk("rot_clr_pulses", clr_cnt_b, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
